adma_descriptor_responder: RTL and testbench

//  Memory-side responder for ADMA descriptor fetches. Holds the ADMA2 descriptor table

---
 rtl/adma_descriptor_responder_if.sv | 32 +++
 rtl/adma_descriptor_responder.sv | 130 +++++++++++++
 tb/tb_adma_descriptor_responder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adma_descriptor_responder_if.sv
// Handshake bundle between the ADMA engine / host software and the descriptor
// responder: fetch port, table write port, clear pulse and fetch counter.
interface adma_descriptor_responder_if #(
  parameter int IDX_W = 5
);
  logic [63:0]      Table_Base_Address;
  logic             enb_Descriptor_Fetch;
  logic [63:0]      Descriptor_Address;
  logic             ack_Descriptor_Fetch;
  logic [95:0]      Descriptor_Line;
  logic             Descriptor_Error;
  logic             enb_Table_Write;
  logic [IDX_W-1:0] Table_Write_Index;
  logic [95:0]      Table_Write_Data;
  logic             ack_Table_Write;
  logic             Table_Clear;
  logic [15:0]      Fetch_Count;

  modport master (
    output Table_Base_Address, enb_Descriptor_Fetch, Descriptor_Address,
           enb_Table_Write, Table_Write_Index, Table_Write_Data, Table_Clear,
    input  ack_Descriptor_Fetch, Descriptor_Line, Descriptor_Error,
           ack_Table_Write, Fetch_Count
  );

  modport slave (
    input  Table_Base_Address, enb_Descriptor_Fetch, Descriptor_Address,
           enb_Table_Write, Table_Write_Index, Table_Write_Data, Table_Clear,
    output ack_Descriptor_Fetch, Descriptor_Line, Descriptor_Error,
           ack_Table_Write, Fetch_Count
  );
endinterface

// File: rtl/adma_descriptor_responder.sv
// Memory-side responder for ADMA2 descriptor fetches: a host-written descriptor
// table served to the ADMA engine over four-phase enb/ack handshakes.
module adma_descriptor_responder #(
  parameter int DEPTH        = 32,
  parameter int IDX_W        = $clog2(DEPTH),
  parameter int READ_LATENCY = 2
) (
  input  logic clk,
  input  logic rst_n,
  adma_descriptor_responder_if.slave bus
);

  typedef enum logic [1:0] {F_IDLE, F_WAIT, F_ACK} fetch_state_t;
  typedef enum logic       {W_IDLE, W_ACK}         write_state_t;

  fetch_state_t     f_state, f_next;
  write_state_t     w_state, w_next;

  logic [95:0]      mem [DEPTH];
  logic [DEPTH-1:0] written;

  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic [2:0]       lat_cnt;
  logic [95:0]      line_q;
  logic [15:0]      count_q;

  logic             capture, load_line, complete, w_accept;
  logic [63:0]      offset;
  logic             addr_err;

  // Entry stride is 8 bytes; anything outside the table or off the 8-byte grid is an error.
  assign offset   = bus.Descriptor_Address - bus.Table_Base_Address;
  assign addr_err = (offset[2:0] != 3'd0) || (offset[63:IDX_W+3] != '0);

  // ---------------- fetch FSM ----------------
  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_state <= F_IDLE;
    else        f_state <= f_next;
  end

  // NOTE: every output of this block gets a default first, otherwise a path
  // that does not assign it infers a latch.
  always_comb begin
    f_next    = f_state;
    capture   = 1'b0;
    load_line = 1'b0;
    complete  = 1'b0;
    unique case (f_state)
      F_IDLE: if (bus.enb_Descriptor_Fetch) begin
        capture = 1'b1;
        f_next  = F_WAIT;
      end
      F_WAIT: if (lat_cnt == 3'd0) begin
        load_line = 1'b1;
        f_next    = F_ACK;
      end
      F_ACK: if (!bus.enb_Descriptor_Fetch) begin
        complete = 1'b1;
        f_next   = F_IDLE;
      end
      default: f_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      err_q   <= 1'b0;
      lat_cnt <= '0;
      line_q  <= '0;
      count_q <= '0;
    end else begin
      if (capture) begin
        idx_q   <= offset[IDX_W+2:3];
        err_q   <= addr_err;
        lat_cnt <= 3'(READ_LATENCY - 1);
      end else if (f_state == F_WAIT && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
      // A write committing on this same edge is not yet in mem, so old data wins.
      if (load_line)
        line_q <= (err_q || !written[idx_q]) ? '0 : mem[idx_q];
      if (complete)
        count_q <= count_q + 16'd1;
    end
  end

  assign bus.ack_Descriptor_Fetch = (f_state == F_ACK);
  assign bus.Descriptor_Error     = (f_state == F_ACK) && err_q;
  assign bus.Descriptor_Line      = line_q;
  assign bus.Fetch_Count          = count_q;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next   = w_state;
    w_accept = 1'b0;
    unique case (w_state)
      W_IDLE: if (bus.enb_Table_Write) begin
        w_accept = 1'b1;
        w_next   = W_ACK;
      end
      W_ACK: if (!bus.enb_Table_Write) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // NOTE: the data array is deliberately not reset; the written vector alone
  // decides whether an entry reads back as a descriptor or as zero.
  always_ff @(posedge clk) begin
    if (w_accept) mem[bus.Table_Write_Index] <= bus.Table_Write_Data;
  end

  // Clear beats a same-edge write: the write is acknowledged but stays invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               written <= '0;
    else if (bus.Table_Clear) written <= '0;
    else if (w_accept)        written[bus.Table_Write_Index] <= 1'b1;
  end

  assign bus.ack_Table_Write = (w_state == W_ACK);

endmodule

// File: tb/tb_adma_descriptor_responder.sv
// Directed-vector bench for adma_descriptor_responder: fetch latency, decode
// errors, clear, same-edge write/read ordering, hold, counter wrap and reset abort.
module tb_adma_descriptor_responder;
  localparam int DEPTH = 32;
  localparam int IDX_W = 5;
  localparam logic [63:0] BASE = 64'h1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_bad = 0;
  int exp_count = 0;

  adma_descriptor_responder_if #(.IDX_W(IDX_W)) bus ();

  adma_descriptor_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .READ_LATENCY(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mk_line(input logic [63:0] a, input logic [15:0] len,
                                          input logic [1:0] act, input logic v);
    mk_line = {a, len, 10'd0, act, 1'b0, 1'b0, 1'b0, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full write handshake; called and returns at a negedge.
  task automatic do_write(input logic [IDX_W-1:0] idx, input logic [95:0] data);
    int n;
    bus.Table_Write_Index = idx;
    bus.Table_Write_Data  = data;
    bus.enb_Table_Write   = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bus.ack_Table_Write && n < 10);
    n_vec++;
    if (bus.ack_Table_Write !== 1'b1 || n != 1) begin
      n_bad++;
      $display("FAIL write_ack idx%0d: ack=%b after %0d edges, required ack=1 after 1", idx, bus.ack_Table_Write, n);
    end
    bus.enb_Table_Write = 1'b0;
    tick();
  endtask

  // Full fetch handshake; reports edges-to-ack, sampled line and error.
  task automatic do_fetch(input logic [63:0] addr, output logic [95:0] line,
                          output logic err, output int lat);
    bus.Descriptor_Address   = addr;
    bus.enb_Descriptor_Fetch = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!bus.ack_Descriptor_Fetch && lat < 20);
    if (!bus.ack_Descriptor_Fetch) begin
      n_vec++; n_bad++;
      $display("FAIL fetch_timeout addr=%h: no ack within 20 edges", addr);
    end
    line = bus.Descriptor_Line;
    err  = bus.Descriptor_Error;
    bus.enb_Descriptor_Fetch = 1'b0;
    tick();
    exp_count++;
    n_vec++;
    if (bus.ack_Descriptor_Fetch !== 1'b0 || bus.Descriptor_Error !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_release addr=%h: ack=%b err=%b, required 0/0", addr,
               bus.ack_Descriptor_Fetch, bus.Descriptor_Error);
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (bus.ack_Descriptor_Fetch !== 1'b0 || bus.ack_Table_Write !== 1'b0 ||
        bus.Descriptor_Error !== 1'b0 || bus.Descriptor_Line !== 96'h0 || bus.Fetch_Count !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: ackf=%b ackw=%b err=%b line=%h cnt=%h, required all 0",
               bus.ack_Descriptor_Fetch, bus.ack_Table_Write, bus.Descriptor_Error,
               bus.Descriptor_Line, bus.Fetch_Count);
    end
  endtask

  task automatic test_basic_fetch();
    logic [95:0] l; logic e; int lat;
    logic [95:0] exp_l;
    exp_l = mk_line(64'hABCD0000, 16'h0200, 2'b10, 1'b1);
    do_write(5'd3, exp_l);
    do_fetch(BASE + 64'h18, l, e, lat);
    n_vec++;
    if (lat != 3) begin n_bad++; $display("FAIL basic_latency: %0d edges, required 3", lat); end
    n_vec++;
    if (l !== exp_l || e !== 1'b0) begin
      n_bad++; $display("FAIL basic_line: line=%h err=%b, required %h/0", l, e, exp_l);
    end
    n_vec++;
    if (bus.Fetch_Count !== 16'd1) begin
      n_bad++; $display("FAIL basic_count: %0d, required 1", bus.Fetch_Count);
    end
    // Last entry of the table is still in range.
    exp_l = mk_line(64'h0123_4567_89AB_CDE8, 16'hFFFF, 2'b11, 1'b1);
    do_write(5'd31, exp_l);
    do_fetch(BASE + 64'hF8, l, e, lat);
    n_vec++;
    if (l !== exp_l || e !== 1'b0) begin
      n_bad++; $display("FAIL last_entry: line=%h err=%b, required %h/0", l, e, exp_l);
    end
  endtask

  task automatic test_errors();
    logic [95:0] l; logic e; int lat;
    logic [63:0] addrs [3];
    addrs[0] = BASE + 64'h4;
    addrs[1] = BASE + 64'(8 * DEPTH);
    addrs[2] = BASE - 64'h8;
    for (int i = 0; i < 3; i++) begin
      do_fetch(addrs[i], l, e, lat);
      n_vec++;
      if (l !== 96'h0 || e !== 1'b1) begin
        n_bad++; $display("FAIL error_addr %h: line=%h err=%b, required 0/1", addrs[i], l, e);
      end
    end
  endtask

  task automatic test_clear();
    logic [95:0] l; logic e; int lat;
    do_fetch(BASE, l, e, lat);
    n_vec++;
    if (l !== 96'h0 || e !== 1'b0) begin
      n_bad++; $display("FAIL unwritten_idx0: line=%h err=%b, required 0/0", l, e);
    end
    bus.Table_Clear = 1'b1;
    tick();
    bus.Table_Clear = 1'b0;
    do_fetch(BASE + 64'h18, l, e, lat);
    n_vec++;
    if (l !== 96'h0 || e !== 1'b0) begin
      n_bad++; $display("FAIL cleared_idx3: line=%h err=%b, required 0/0", l, e);
    end
    // Write and clear on the same edge: write acked, entry stays invalid.
    bus.Table_Write_Index = 5'd7;
    bus.Table_Write_Data  = mk_line(64'h7777, 16'h7, 2'b01, 1'b1);
    bus.enb_Table_Write   = 1'b1;
    bus.Table_Clear       = 1'b1;
    tick();
    bus.Table_Clear = 1'b0;
    n_vec++;
    if (bus.ack_Table_Write !== 1'b1) begin
      n_bad++; $display("FAIL clear_write_ack: ack=%b, required 1", bus.ack_Table_Write);
    end
    bus.enb_Table_Write = 1'b0;
    tick();
    do_fetch(BASE + 64'h38, l, e, lat);
    n_vec++;
    if (l !== 96'h0) begin
      n_bad++; $display("FAIL clear_priority idx7: line=%h, required 0", l);
    end
  endtask

  task automatic test_same_edge();
    logic [95:0] l; logic e; int lat;
    logic [95:0] old_l, new_l;
    old_l = mk_line(64'h5555_0000, 16'h0050, 2'b10, 1'b1);
    new_l = mk_line(64'h5A5A_0000, 16'h0A50, 2'b11, 1'b1);
    do_write(5'd5, old_l);
    bus.Descriptor_Address   = BASE + 64'h28;
    bus.enb_Descriptor_Fetch = 1'b1;
    tick();
    tick();
    bus.Table_Write_Index = 5'd5;
    bus.Table_Write_Data  = new_l;
    bus.enb_Table_Write   = 1'b1;
    tick();
    n_vec++;
    if (bus.ack_Descriptor_Fetch !== 1'b1 || bus.ack_Table_Write !== 1'b1 || bus.Descriptor_Line !== old_l) begin
      n_bad++;
      $display("FAIL same_edge: ackf=%b ackw=%b line=%h, required 1/1/%h",
               bus.ack_Descriptor_Fetch, bus.ack_Table_Write, bus.Descriptor_Line, old_l);
    end
    bus.enb_Descriptor_Fetch = 1'b0;
    bus.enb_Table_Write      = 1'b0;
    tick();
    exp_count++;
    do_fetch(BASE + 64'h28, l, e, lat);
    n_vec++;
    if (l !== new_l) begin
      n_bad++; $display("FAIL after_same_edge: line=%h, required %h", l, new_l);
    end
  endtask

  task automatic test_hold_and_wrap();
    logic [95:0] l; logic e; int lat;
    logic [95:0] exp_l;
    int bad_cycles;
    exp_l = mk_line(64'h5A5A_0000, 16'h0A50, 2'b11, 1'b1);
    bus.Descriptor_Address   = BASE + 64'h28;
    bus.enb_Descriptor_Fetch = 1'b1;
    lat = 0;
    do begin tick(); lat++; end while (!bus.ack_Descriptor_Fetch && lat < 20);
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.ack_Descriptor_Fetch !== 1'b1 || bus.Descriptor_Line !== exp_l ||
          bus.Fetch_Count !== 16'(exp_count)) bad_cycles++;
      tick();
    end
    n_vec++;
    if (bad_cycles != 0) begin
      n_bad++; $display("FAIL hold_stable: %0d unstable cycles, required 0", bad_cycles);
    end
    bus.enb_Descriptor_Fetch = 1'b0;
    tick();
    exp_count++;
    n_vec++;
    if (bus.Fetch_Count !== 16'(exp_count) || bus.Descriptor_Line !== exp_l) begin
      n_bad++; $display("FAIL hold_release: cnt=%0d line=%h, required %0d/%h",
                        bus.Fetch_Count, bus.Descriptor_Line, exp_count, exp_l);
    end
    // Jump the counter near its wrap point instead of spending 64k fetches.
    force dut.count_q = 16'hFFFE;
    tick();
    release dut.count_q;
    do_fetch(BASE, l, e, lat);
    n_vec++;
    if (bus.Fetch_Count !== 16'hFFFF) begin
      n_bad++; $display("FAIL count_ffff: %h, required ffff", bus.Fetch_Count);
    end
    do_fetch(BASE, l, e, lat);
    n_vec++;
    if (bus.Fetch_Count !== 16'h0000) begin
      n_bad++; $display("FAIL count_wrap: %h, required 0000", bus.Fetch_Count);
    end
  endtask

  task automatic test_reset_abort();
    logic [95:0] l; logic e; int lat;
    int ack_seen;
    logic [95:0] exp_l;
    bus.Descriptor_Address   = BASE + 64'h28;
    bus.enb_Descriptor_Fetch = 1'b1;
    tick();
    rst_n = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ack_Descriptor_Fetch !== 1'b0) ack_seen++;
    end
    n_vec++;
    if (ack_seen != 0 || bus.Descriptor_Line !== 96'h0 || bus.Fetch_Count !== 16'h0 ||
        bus.Descriptor_Error !== 1'b0) begin
      n_bad++; $display("FAIL reset_abort: ack_cycles=%0d line=%h cnt=%h err=%b, required 0/0/0/0",
                        ack_seen, bus.Descriptor_Line, bus.Fetch_Count, bus.Descriptor_Error);
    end
    bus.enb_Descriptor_Fetch = 1'b0;
    rst_n = 1'b1;
    tick();
    do_fetch(BASE + 64'h28, l, e, lat);
    n_vec++;
    if (l !== 96'h0 || e !== 1'b0 || lat != 3) begin
      n_bad++; $display("FAIL table_empty_after_reset: line=%h err=%b lat=%0d, required 0/0/3", l, e, lat);
    end
    exp_l = mk_line(64'hDEAD_BEE0, 16'h0010, 2'b10, 1'b1);
    do_write(5'd2, exp_l);
    do_fetch(BASE + 64'h10, l, e, lat);
    n_vec++;
    if (l !== exp_l || bus.Fetch_Count !== 16'd2) begin
      n_bad++; $display("FAIL post_reset_fetch: line=%h cnt=%0d, required %h/2", l, bus.Fetch_Count, exp_l);
    end
  endtask

  initial begin
    bus.Table_Base_Address   = BASE;
    bus.enb_Descriptor_Fetch = 1'b0;
    bus.Descriptor_Address   = '0;
    bus.enb_Table_Write      = 1'b0;
    bus.Table_Write_Index    = '0;
    bus.Table_Write_Data     = '0;
    bus.Table_Clear          = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    tick();
    test_basic_fetch();
    test_errors();
    test_clear();
    test_same_edge();
    test_hold_and_wrap();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
